// File: rtl/ycbcr_to_rgb.sv
// Full-range BT.601 YCbCr -> 24-bit RGB: offset, multiply, then sum/round/clamp, one pixel per clock.
// Latency 3 clocks from input transfer to out_valid; each stalled cycle adds one.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready in the same cycle.
module ycbcr_to_rgb #(
    parameter int C_RV = 359,
    parameter int C_GU = 88,
    parameter int C_GV = 183,
    parameter int C_BU = 454
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] YCbCr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] RGB
);

    localparam logic signed [19:0] K_RV = 20'(C_RV);
    localparam logic signed [19:0] K_GU = 20'(C_GU);
    localparam logic signed [19:0] K_GV = 20'(C_GV);
    localparam logic signed [19:0] K_BU = 20'(C_BU);

    logic                en;

    logic                valid1;
    logic [7:0]          y1;
    logic signed [8:0]   u1;
    logic signed [8:0]   v1;
    logic signed [19:0]  u_ext;
    logic signed [19:0]  v_ext;

    logic                valid2;
    logic signed [19:0]  y256;
    logic signed [19:0]  prv;
    logic signed [19:0]  pgu;
    logic signed [19:0]  pgv;
    logic signed [19:0]  pbu;

    logic signed [19:0]  accr;
    logic signed [19:0]  accg;
    logic signed [19:0]  accb;

    // The whole pipe moves as one: any slot may be a bubble, so only the output slot can stall it.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    assign u_ext = {{11{u1[8]}}, u1};
    assign v_ext = {{11{v1[8]}}, v1};

    // +128 before the arithmetic shift gives round-half-up on the Q.8 result.
    assign accr = y256 + prv + 20'sd128;
    assign accg = y256 - pgu - pgv + 20'sd128;
    assign accb = y256 + pbu + 20'sd128;

    function automatic logic [7:0] clamp8(input logic signed [19:0] acc);
        if (acc < 0)
            return 8'd0;
        else if (acc > 20'sd65535)
            return 8'hFF;
        else
            return acc[15:8];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid1    <= 1'b0;
            y1        <= '0;
            u1        <= '0;
            v1        <= '0;
            valid2    <= 1'b0;
            y256      <= '0;
            prv       <= '0;
            pgu       <= '0;
            pgv       <= '0;
            pbu       <= '0;
            out_valid <= 1'b0;
            RGB       <= '0;
        end else if (en) begin
            valid1    <= in_valid;
            y1        <= YCbCr[7:0];
            u1        <= $signed({1'b0, YCbCr[15:8]}) - 9'sd128;
            v1        <= $signed({1'b0, YCbCr[23:16]}) - 9'sd128;

            valid2    <= valid1;
            y256      <= $signed({4'b0, y1, 8'b0});
            prv       <= K_RV * v_ext;
            pgu       <= K_GU * u_ext;
            pgv       <= K_GV * v_ext;
            pbu       <= K_BU * u_ext;

            out_valid <= valid2;
            RGB       <= {clamp8(accr), clamp8(accg), clamp8(accb)};
        end
    end

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Bench for ycbcr_to_rgb: directed colour points, reset flush, full-pipe stall and a random stream
// scored against an integer-arithmetic colour model.
module tb_ycbcr_to_rgb;

    localparam int C_RV = 359;
    localparam int C_GU = 88;
    localparam int C_GV = 183;
    localparam int C_BU = 454;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] YCbCr;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] RGB;

    int          n_checks;
    int          n_errors;
    int          n_acc;
    logic [23:0] exp_q[$];
    logic        prev_stall;
    logic [23:0] prev_rgb;

    ycbcr_to_rgb #(
        .C_RV(C_RV),
        .C_GU(C_GU),
        .C_GV(C_GV),
        .C_BU(C_BU)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .YCbCr    (YCbCr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .RGB      (RGB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary, required to finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_ch(input int acc);
        int ch;
        ch = acc >>> 8;
        if (ch < 0) ch = 0;
        if (ch > 255) ch = 255;
        return ch[7:0];
    endfunction

    function automatic logic [23:0] ref_rgb(input logic [23:0] ycc);
        int y, u, v;
        y = int'(ycc[7:0]);
        u = int'(ycc[15:8]) - 128;
        v = int'(ycc[23:16]) - 128;
        return {ref_ch(y * 256 + C_RV * v + 128),
                ref_ch(y * 256 - C_GU * u - C_GV * v + 128),
                ref_ch(y * 256 + C_BU * u + 128)};
    endfunction

    // One clock: drive on the falling edge, let the handshake settle, then score
    // what this cycle will transfer and verify stalled outputs held.
    task automatic step(input logic v, input logic [23:0] d, input logic ordy, input logic r);
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        YCbCr     = d;
        out_ready = ordy;
        #1;
        if (prev_stall) begin
            chk("hold_vld", {31'd0, out_valid}, 32'd1);
            chk("hold_rgb", {8'd0, RGB}, {8'd0, prev_rgb});
        end
        if (!r) begin
            exp_q.delete();
        end else begin
            if (v && in_ready) begin
                exp_q.push_back(ref_rgb(d));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    chk("spurious_out", {8'd0, RGB}, 32'hFFFF_FFFF);
                else
                    chk("stream_rgb", {8'd0, RGB}, {8'd0, exp_q.pop_front()});
            end
        end
        prev_stall = r && out_valid && !out_ready;
        prev_rgb   = RGB;
    endtask

    task automatic send_one(input string tag, input logic [23:0] d, input logic [23:0] exp);
        int lat;
        step(1'b1, d, 1'b1, 1'b1);
        lat = 0;
        while (lat < 10) begin
            step(1'b0, 24'd0, 1'b1, 1'b1);
            lat++;
            if (out_valid) break;
        end
        chk({tag, "_lat"}, lat, 3);
        chk(tag, {8'd0, RGB}, {8'd0, exp});
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        n_acc      = 0;
        prev_stall = 1'b0;
        prev_rgb   = '0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        YCbCr      = '0;

        step(1'b0, 24'd0, 1'b0, 1'b0);
        step(1'b0, 24'd0, 1'b0, 1'b0);
        step(1'b0, 24'd0, 1'b1, 1'b1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rgb", {8'd0, RGB}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send_one("grey", 24'h80_80_80, 24'h808080);
        send_one("red_gclamp", {8'd255, 8'd85, 8'd76}, 24'hFE0000);
        send_one("rclamp_hi", {8'd128, 8'd128, 8'd255} ^ 24'h7F0000 ^ 24'h7F0000 | 24'h0000FF
                 | {8'd255, 8'd0, 8'd0}, 24'hFFA4FF);
        send_one("blue_gclamp", {8'd128, 8'd255, 8'd0}, 24'h0000E1);

        // Reset with three pixels in flight: none of them may surface.
        step(1'b1, 24'h102030, 1'b1, 1'b1);
        step(1'b1, 24'h405060, 1'b1, 1'b1);
        step(1'b1, 24'h708090, 1'b1, 1'b1);
        step(1'b0, 24'd0, 1'b1, 1'b0);
        step(1'b0, 24'd0, 1'b1, 1'b1);
        chk("flush_vld", {31'd0, out_valid}, 32'd0);
        chk("flush_rgb", {8'd0, RGB}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 24'd0, 1'b1, 1'b1);
            chk("flush_quiet", {31'd0, out_valid}, 32'd0);
        end
        send_one("post_rst", 24'h80_80_80, 24'h808080);

        // Fill the pipe behind a stalled output, then poke it while full.
        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b1);
            chk("full_in_rdy", {31'd0, in_ready}, 32'd0);
            chk("full_out_vld", {31'd0, out_valid}, 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 24'd0, 1'b1, 1'b1);
            chk("drain_burst", {31'd0, out_valid}, 32'd1);
        end
        step(1'b0, 24'd0, 1'b1, 1'b1);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        // Random stream with random backpressure.
        n_acc = 0;
        for (int i = 0; i < 400 && n_acc < 40; i++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1, 1'b1);
        chk("stream_count_ok", {31'd0, n_acc >= 16}, 32'd1);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            step(1'b0, 24'd0, $urandom_range(0, 2) != 0, 1'b1);
        chk("stream_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
